// File: rtl/energy_threshold_estimator_pkg.sv
// Shared constants for the energy/threshold estimator: widths, FSM encoding and TH floor helper.
package energy_threshold_estimator_pkg;

   localparam int unsigned ACC_W        = 64;
   localparam int unsigned SAMPLE_W_DEF = 16;

   localparam logic [0:0] ST_INIT  = 1'b0;
   localparam logic [0:0] ST_TRACK = 1'b1;

   function automatic logic [ACC_W-1:0] th_floor(input logic [ACC_W-1:0] i_val,
                                                 input logic [ACC_W-1:0] i_min);
      return (i_val < i_min) ? i_min : i_val;
   endfunction

endpackage

// File: rtl/energy_threshold_estimator_window_energy_acc.sv
// Two-stage square/accumulate over fixed windows of 2^WIN_LOG2 valid samples.
module window_energy_acc
   import energy_threshold_estimator_pkg::*;
#(
   parameter int unsigned SAMPLE_W = SAMPLE_W_DEF,
   parameter int unsigned WIN_LOG2 = 8
) (
   input  logic                       i_clock,
   input  logic                       i_reset,
   input  logic signed [SAMPLE_W-1:0] i_sample_in,
   input  logic                       i_sample_valid,
   output logic [ACC_W-1:0]           o_energy,
   output logic                       o_energy_valid,
   output logic                       o_win_done,
   output logic [ACC_W-1:0]           o_win_energy
);

   localparam int unsigned SQ_W = 2 * SAMPLE_W;

   logic signed [SQ_W-1:0] w_sample_ext;
   logic signed [SQ_W-1:0] w_sq_s;
   logic [SQ_W-1:0]        r_sq;
   logic                   r_sq_vld;
   logic [ACC_W-1:0]       r_acc;
   logic [ACC_W-1:0]       w_sum;
   logic [ACC_W-1:0]       r_energy;
   logic                   r_energy_valid;
   logic [WIN_LOG2-1:0]    r_cnt;

   // Square of the sign-extended sample is always non-negative and fits in SQ_W bits.
   assign w_sample_ext = SQ_W'(i_sample_in);
   assign w_sq_s       = w_sample_ext * w_sample_ext;

   assign w_sum        = r_acc + ACC_W'(r_sq);
   assign o_win_done   = r_sq_vld && (r_cnt == {WIN_LOG2{1'b1}});
   assign o_win_energy = w_sum;

   always_ff @(posedge i_clock or negedge i_reset) begin
      if (!i_reset) begin
         r_sq           <= '0;
         r_sq_vld       <= 1'b0;
         r_acc          <= '0;
         r_energy       <= '0;
         r_energy_valid <= 1'b0;
         r_cnt          <= '0;
      end else begin
         r_sq           <= $unsigned(w_sq_s);
         r_sq_vld       <= i_sample_valid;
         r_energy_valid <= o_win_done;
         if (r_sq_vld) begin
            r_cnt <= r_cnt + 1'b1;
            if (o_win_done) begin
               r_acc    <= '0;
               r_energy <= w_sum;
            end else begin
               r_acc <= w_sum;
            end
         end
      end
   end

   assign o_energy       = r_energy;
   assign o_energy_valid = r_energy_valid;

endmodule

// File: rtl/energy_threshold_estimator.sv
// Window energy estimator with learned noise-floor threshold (init average, then EMA tracking).
module energy_threshold_estimator
   import energy_threshold_estimator_pkg::*;
#(
   parameter int unsigned      SAMPLE_W    = SAMPLE_W_DEF,
   parameter int unsigned      WIN_LOG2    = 8,
   parameter int unsigned      INIT_LOG2   = 4,
   parameter int unsigned      ALPHA_SHIFT = 3,
   parameter logic [ACC_W-1:0] TH_MIN      = 64'd1
) (
   input  logic                       i_clock,
   input  logic                       i_reset,
   input  logic signed [SAMPLE_W-1:0] i_sample_in,
   input  logic                       i_sample_valid,
   input  logic                       i_event_detected,
   output logic [ACC_W-1:0]           o_energy,
   output logic [ACC_W-1:0]           o_th,
   output logic                       o_energy_valid,
   output logic                       o_init_done
);

   localparam int unsigned SUM_W = ACC_W + INIT_LOG2;

   logic                 w_win_done;
   logic [ACC_W-1:0]     w_win_energy;
   logic [0:0]           r_state;
   logic [INIT_LOG2-1:0] r_win_cnt;
   logic [SUM_W-1:0]     r_init_sum;
   logic [SUM_W-1:0]     w_init_total;
   logic [ACC_W-1:0]     w_init_avg;
   logic [ACC_W:0]       w_track_sum;
   logic [ACC_W-1:0]     w_track_th;
   logic [ACC_W-1:0]     r_th;
   logic                 r_init_done;

   window_energy_acc #(
      .SAMPLE_W(SAMPLE_W),
      .WIN_LOG2(WIN_LOG2)
   ) u_acc (
      .i_clock       (i_clock),
      .i_reset       (i_reset),
      .i_sample_in   (i_sample_in),
      .i_sample_valid(i_sample_valid),
      .o_energy      (o_energy),
      .o_energy_valid(o_energy_valid),
      .o_win_done    (w_win_done),
      .o_win_energy  (w_win_energy)
   );

   assign w_init_total = r_init_sum + SUM_W'(w_win_energy);
   assign w_init_avg   = ACC_W'(w_init_total >> INIT_LOG2);

   // TH - TH>>a never underflows, so one extra bit is enough to catch overflow.
   assign w_track_sum = {1'b0, r_th} - {1'b0, r_th >> ALPHA_SHIFT}
                      + {1'b0, w_win_energy >> ALPHA_SHIFT};
   assign w_track_th  = w_track_sum[ACC_W] ? {ACC_W{1'b1}} : w_track_sum[ACC_W-1:0];

   always_ff @(posedge i_clock or negedge i_reset) begin
      if (!i_reset) begin
         r_state     <= ST_INIT;
         r_win_cnt   <= '0;
         r_init_sum  <= '0;
         r_th        <= '0;
         r_init_done <= 1'b0;
      end else if (w_win_done) begin
         case (r_state)
            ST_INIT: begin
               r_win_cnt  <= r_win_cnt + 1'b1;
               r_init_sum <= w_init_total;
               if (r_win_cnt == {INIT_LOG2{1'b1}}) begin
                  r_th        <= th_floor(w_init_avg, TH_MIN);
                  r_init_done <= 1'b1;
                  r_state     <= ST_TRACK;
               end
            end
            ST_TRACK: begin
               if (!i_event_detected) r_th <= th_floor(w_track_th, TH_MIN);
            end
            default: r_state <= ST_INIT;
         endcase
      end
   end

   assign o_th        = r_th;
   assign o_init_done = r_init_done;

endmodule

// File: tb/tb_energy_threshold_estimator.sv
// Directed bench: behavioural window/threshold model checked every cycle plus literal expectations.
module tb_energy_threshold_estimator;

   logic               clk;
   logic               rst_n;
   logic signed [15:0] sample;
   logic               svalid;
   logic               ev;
   logic [63:0]        o_energy;
   logic [63:0]        o_th;
   logic               o_energy_valid;
   logic               o_init_done;

   int total = 0;
   int bad   = 0;

   energy_threshold_estimator dut (
      .i_clock         (clk),
      .i_reset         (rst_n),
      .i_sample_in     (sample),
      .i_sample_valid  (svalid),
      .i_event_detected(ev),
      .o_energy        (o_energy),
      .o_th            (o_th),
      .o_energy_valid  (o_energy_valid),
      .o_init_done     (o_init_done)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   // ---------------- behavioural model ----------------
   function automatic logic [63:0] sq_of(input logic signed [15:0] s);
      longint v;
      v = longint'(s);
      return 64'(v * v);
   endfunction

   function automatic logic [63:0] clamp_th(input logic [71:0] v);
      if (v > {8'd0, 64'hFFFF_FFFF_FFFF_FFFF}) return 64'hFFFF_FFFF_FFFF_FFFF;
      if (v < 72'd1) return 64'd1;
      return v[63:0];
   endfunction

   function automatic logic [63:0] track_th(input logic [63:0] th, input logic [63:0] e);
      logic [71:0] t;
      t = {8'd0, th} - {8'd0, th} / 8 + {8'd0, e} / 8;
      return clamp_th(t);
   endfunction

   logic [63:0] m_acc;
   int          m_cnt;
   int          m_wins;
   logic [71:0] m_init_sum;
   logic        m_pend;
   logic [63:0] m_pend_e;
   logic [63:0] exp_energy;
   logic [63:0] exp_th;
   logic        exp_valid;
   logic        exp_init;

   // A window closes on the edge its last sample is taken; outputs appear one edge later.
   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         m_acc      <= '0;
         m_cnt      <= 0;
         m_wins     <= 0;
         m_init_sum <= '0;
         m_pend     <= 1'b0;
         m_pend_e   <= '0;
         exp_energy <= '0;
         exp_th     <= '0;
         exp_valid  <= 1'b0;
         exp_init   <= 1'b0;
      end else begin
         exp_valid <= 1'b0;
         if (m_pend) begin
            exp_valid  <= 1'b1;
            exp_energy <= m_pend_e;
            if (!exp_init) begin
               if (m_wins == 15) begin
                  exp_th   <= clamp_th((m_init_sum + {8'd0, m_pend_e}) / 16);
                  exp_init <= 1'b1;
               end
               m_init_sum <= m_init_sum + {8'd0, m_pend_e};
               m_wins     <= m_wins + 1;
            end else if (!ev) begin
               exp_th <= track_th(exp_th, m_pend_e);
            end
         end
         m_pend <= 1'b0;
         if (svalid) begin
            if (m_cnt == 255) begin
               m_pend   <= 1'b1;
               m_pend_e <= m_acc + sq_of(sample);
               m_acc    <= '0;
               m_cnt    <= 0;
            end else begin
               m_acc <= m_acc + sq_of(sample);
               m_cnt <= m_cnt + 1;
            end
         end
      end
   end

   always @(negedge clk) begin
      check("energy_valid", {63'd0, o_energy_valid}, {63'd0, exp_valid});
      check("energy", o_energy, exp_energy);
      check("th", o_th, exp_th);
      check("init_done", {63'd0, o_init_done}, {63'd0, exp_init});
   end

   // ---------------- stimulus ----------------
   task automatic send(input logic signed [15:0] s, input logic v);
      @(negedge clk);
      sample = s;
      svalid = v;
   endtask

   task automatic send_n(input logic signed [15:0] s, input int n);
      for (int i = 0; i < n; i++) send(s, 1'b1);
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) send(16'sd0, 1'b0);
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst_n  = 1'b0;
      svalid = 1'b0;
      ev     = 1'b0;
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   initial begin
      rst_n  = 1'b1;
      sample = '0;
      svalid = 1'b0;
      ev     = 1'b0;
      #1 rst_n = 1'b0;
      #3;
      check("rst_energy", o_energy, 64'd0);
      check("rst_th", o_th, 64'd0);
      check("rst_valid", {63'd0, o_energy_valid}, 64'd0);
      check("rst_init", {63'd0, o_init_done}, 64'd0);
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b1;

      // Window 1 of constant 100 with latency check.
      send_n(16'sd100, 255);
      send(16'sd100, 1'b1);
      @(posedge clk);
      #1;
      svalid = 1'b0;
      check("lat1_valid", {63'd0, o_energy_valid}, 64'd0);
      @(posedge clk);
      #1;
      check("lat2_valid", {63'd0, o_energy_valid}, 64'd1);
      check("t1_energy", o_energy, 64'd2560000);

      // Windows 2..15 then 16: init forms exactly at the 16th.
      send_n(16'sd100, 256 * 14);
      idle(3);
      check("t2_pre_init", {63'd0, o_init_done}, 64'd0);
      check("t2_pre_th", o_th, 64'd0);
      send_n(16'sd100, 256);
      idle(3);
      check("t2_init", {63'd0, o_init_done}, 64'd1);
      check("t2_th", o_th, 64'd2560000);

      // Tracking: frozen with event, then EMA update.
      ev = 1'b1;
      send_n(16'sd1000, 256);
      idle(3);
      check("t3_energy", o_energy, 64'd256000000);
      check("t3_frozen_th", o_th, 64'd2560000);
      ev = 1'b0;
      send_n(16'sd1000, 256);
      idle(3);
      check("t3_track_th", o_th, 64'd34240000);

      // All-zero init floors TH at 1, tracking keeps it there.
      do_reset();
      send_n(16'sd0, 256 * 16);
      idle(3);
      check("t4_init", {63'd0, o_init_done}, 64'd1);
      check("t4_th_floor", o_th, 64'd1);
      send_n(16'sd0, 256);
      idle(3);
      check("t4_th_track", o_th, 64'd1);

      // Full-scale negative samples with gaps.
      for (int i = 0; i < 256; i++) begin
         send(-16'sd32768, 1'b1);
         send(-16'sd32768, 1'b0);
      end
      idle(3);
      check("t5_energy", o_energy, 64'd274877906944);
      check("t5_th", o_th, 64'd34359738369);

      // Reset mid-window 5, then full re-initialisation.
      do_reset();
      send_n(16'sd100, 256 * 4 + 100);
      @(posedge clk);
      #2;
      rst_n = 1'b0;
      #1;
      check("t6_energy", o_energy, 64'd0);
      check("t6_th", o_th, 64'd0);
      check("t6_valid", {63'd0, o_energy_valid}, 64'd0);
      check("t6_init", {63'd0, o_init_done}, 64'd0);
      svalid = 1'b0;
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      send_n(16'sd100, 256 * 15);
      idle(3);
      check("t6_pre_init", {63'd0, o_init_done}, 64'd0);
      send_n(16'sd100, 256);
      idle(3);
      check("t6_init_done", {63'd0, o_init_done}, 64'd1);
      check("t6_th_final", o_th, 64'd2560000);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
